// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address view, frame layout and controller states.
package cpu_types_pkg;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 30 - IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FILL
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache with zero-wait hits
// and a single-word fill from the memory controller on a miss.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NUM_FRAMES = 16,
    parameter int IDX_W      = IIDX_W,
    parameter int TAG_W      = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } frame_t;

    frame_t        frames [NUM_FRAMES];
    icache_state_t state, next_state;
    logic [31:0]   miss_addr;

    logic [TAG_W-1:0] req_tag, miss_tag;
    logic [IDX_W-1:0] req_idx, miss_idx;
    logic             hit, miss;
    logic             unused_bytoff;

    assign req_tag       = imemaddr[31:32-TAG_W];
    assign req_idx       = imemaddr[IDX_W+1:2];
    assign miss_tag      = miss_addr[31:32-TAG_W];
    assign miss_idx      = miss_addr[IDX_W+1:2];
    assign unused_bytoff = ^imemaddr[1:0];

    // Lookups only count while idle; a fetch seen during FILL is re-evaluated afterwards.
    assign hit  = (state == IDLE) && imemREN && frames[req_idx].valid
                  && (frames[req_idx].tag == req_tag);
    assign miss = (state == IDLE) && imemREN && !hit;

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state)
            IDLE: begin
                ihit     = hit;
                imemload = hit ? frames[req_idx].data : '0;
                if (miss)
                    next_state = FILL;
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (miss)
                miss_addr <= imemaddr;
            if (hit && hit_count != '1)
                hit_count <= hit_count + 32'd1;
            if (miss && miss_count != '1)
                miss_count <= miss_count + 32'd1;
        end
    end

    // A fill overwrites its frame unconditionally: nothing here is ever dirty.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FRAMES; i++)
                frames[i] <= '0;
        end else if (state == FILL && !iwait) begin
            frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a word-address cache model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int tests = 0;
    int fails = 0;
    int lat   = 3;
    int cnt   = 0;

    icache dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        case (w)
            32'h0000_0000: return 32'hAAAA_AAAA;
            32'h0000_0004: return 32'h2401_0001;
            32'h0000_0008: return 32'h8C22_0008;
            32'h0000_0040: return 32'hBBBB_BBBB;
            default:       return {w[15:0], ~w[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory controller: holds iwait high for `lat` cycles of each read, then returns data.
    initial begin
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
    end
    always @(posedge CLK) begin
        #1;
        if (iREN) begin
            if (cnt < lat) begin
                iwait = 1'b1;
                iload = 32'hDEAD_BEEF;
                cnt++;
            end else begin
                iwait = 1'b0;
                iload = mem_word(iaddr);
                cnt   = 0;
            end
        end else begin
            iwait = 1'b1;
            iload = 32'hDEAD_BEEF;
            cnt   = 0;
        end
    end

    // Model: each index remembers which word address it holds; a pending miss blocks lookups.
    logic [31:0] cached [int];
    logic        m_fill = 1'b0;
    logic [31:0] m_miss = '0;
    logic [31:0] m_hc = '0, m_mc = '0;
    logic [31:0] m_word;
    int          m_idx;
    logic        m_hit;

    always @(negedge CLK) begin
        if (!nRST) begin
            cached.delete();
            m_fill = 1'b0;
            m_miss = '0;
            m_hc   = '0;
            m_mc   = '0;
            chk("rst_ihit", {31'd0, ihit}, 32'd0);
            chk("rst_iren", {31'd0, iREN}, 32'd0);
            chk("rst_iaddr", iaddr, 32'd0);
            chk("rst_imemload", imemload, 32'd0);
        end else begin
            m_word = imemaddr >> 2;
            m_idx  = int'(m_word % 16);
            m_hit  = !m_fill && imemREN && cached.exists(m_idx) && cached[m_idx] == m_word;
            chk("m_ihit", {31'd0, ihit}, {31'd0, m_hit});
            chk("m_imemload", imemload, m_hit ? mem_word(imemaddr) : 32'd0);
            chk("m_iren", {31'd0, iREN}, {31'd0, m_fill});
            chk("m_iaddr", iaddr, m_fill ? m_miss : 32'd0);
            chk("m_hit_count", hit_count, m_hc);
            chk("m_miss_count", miss_count, m_mc);
            if (m_fill) begin
                if (!iwait) begin
                    cached[int'((m_miss >> 2) % 16)] = m_miss >> 2;
                    m_fill = 1'b0;
                end
            end else if (imemREN) begin
                if (m_hit) m_hc++;
                else begin
                    m_miss = imemaddr;
                    m_mc++;
                    m_fill = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        nRST    = 1'b0;
        imemREN = 1'b0;
        @(negedge CLK);
        chk("reset_hit_count", hit_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // Requests addr and steps cycles until ihit; returns at the negedge where ihit is seen.
    task automatic wait_hit(input logic [31:0] addr, output int cyc, output int iren_n,
                            output logic [31:0] data);
        imemREN  = 1'b1;
        imemaddr = addr;
        cyc      = -1;
        iren_n   = 0;
        data     = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (ihit) begin
                cyc  = c;
                data = imemload;
                break;
            end
            if (iREN) iren_n++;
            @(posedge CLK);
            #1;
        end
        if (cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL hit_timeout: no ihit for addr %h within 40 cycles", addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, rn, bad, fill_n;
        logic [31:0] d;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        @(posedge CLK);
        #1;

        // Cold miss on 0x4: 4 fill cycles, hit on the 6th cycle of the request.
        do_reset();
        wait_hit(32'h4, cyc, rn, d);
        chk("cold_latency", cyc, 32'd5);
        chk("cold_iren_cycles", rn, 32'd4);
        chk("cold_data", d, 32'h2401_0001);
        chk("cold_miss_count", miss_count, 32'd1);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("repeat_ihit", {31'd0, ihit}, 32'd1);
            chk("repeat_iren", {31'd0, iREN}, 32'd0);
            chk("repeat_data", imemload, 32'h2401_0001);
            if (i == 0) chk("cold_hit_count", hit_count, 32'd1);
            @(posedge CLK);
            #1;
        end
        imemREN = 1'b0;
        @(negedge CLK);
        chk("repeat_hit_count", hit_count, 32'd6);
        @(posedge CLK);
        #1;

        // Conflict eviction at index 0.
        do_reset();
        wait_hit(32'h0, cyc, rn, d);
        chk("conf_first_data", d, 32'hAAAA_AAAA);
        @(posedge CLK);
        #1;
        wait_hit(32'h40, cyc, rn, d);
        chk("conf_evict_latency", cyc, 32'd5);
        chk("conf_evict_data", d, 32'hBBBB_BBBB);
        @(posedge CLK);
        #1;
        wait_hit(32'h0, cyc, rn, d);
        chk("conf_refetch_latency", cyc, 32'd5);
        chk("conf_refetch_data", d, 32'hAAAA_AAAA);
        chk("conf_miss_count", miss_count, 32'd3);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;

        // Squash during fill: addresses chosen at different indices so both stay resident.
        do_reset();
        imemREN  = 1'b1;
        imemaddr = 32'h104;
        repeat (3) begin
            @(negedge CLK);
            @(posedge CLK);
            #1;
        end
        imemaddr = 32'h208;
        bad      = 0;
        fill_n   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!iREN) break;
            if (iaddr != 32'h104) bad++;
            fill_n++;
            @(posedge CLK);
            #1;
        end
        chk("squash_tail_cycles", fill_n, 32'd2);
        chk("squash_iaddr_changes", bad, 32'd0);
        @(posedge CLK);
        #1;
        wait_hit(32'h208, cyc, rn, d);
        chk("squash_new_latency", cyc, 32'd4);
        chk("squash_new_data", d, 32'h0208_FDF7);
        @(posedge CLK);
        #1;
        wait_hit(32'h104, cyc, rn, d);
        chk("squash_old_hit", cyc, 32'd0);
        chk("squash_old_data", d, 32'h0104_FEFB);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;

        // Reset in the middle of a fill.
        do_reset();
        imemREN  = 1'b1;
        imemaddr = 32'h300;
        repeat (2) begin
            @(negedge CLK);
            @(posedge CLK);
            #1;
        end
        chk("midrst_pre_iren", {31'd0, iREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_iren", {31'd0, iREN}, 32'd0);
        chk("midrst_iaddr", iaddr, 32'd0);
        chk("midrst_miss_count", miss_count, 32'd0);
        chk("midrst_hit_count", hit_count, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        wait_hit(32'h300, cyc, rn, d);
        chk("midrst_refetch_latency", cyc, 32'd5);
        chk("midrst_refetch_data", d, 32'h0300_FCFF);
        @(posedge CLK);
        #1;

        // Byte offset ignored.
        wait_hit(32'h8, cyc, rn, d);
        chk("byte_fill_data", d, 32'h8C22_0008);
        @(posedge CLK);
        #1;
        imemaddr = 32'hB;
        @(negedge CLK);
        chk("byte_ihit", {31'd0, ihit}, 32'd1);
        chk("byte_data", imemload, 32'h8C22_0008);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
        repeat (2) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
